seq_div16: RTL and testbench

SEQ_DIV16 -- requirements
Module: seq_div16

---
 rtl/seq_div16.sv | 97 +++++++++
 tb/tb_seq_div16.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div16.sv
// seq_div16: 16-bit by 8-bit unsigned restoring divider, one quotient bit per clock.
// Results are registered and update only on the FIN edge; divide-by-zero skips the
// iteration phase and reports a saturated quotient with the low dividend byte as remainder.
`timescale 1ns/1ps
module seq_div16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state_reg;
  logic [15:0] work_reg;   // dividend bits shift out the top, quotient bits shift in at the bottom
  logic [7:0]  dsr_reg;    // captured divisor
  logic [8:0]  prem_reg;   // partial remainder, one bit wider than the divisor
  logic [4:0]  cnt_reg;    // iteration counter, 0..15 during CALC

  logic [9:0]  trial;
  logic        trial_ok;

  // Trial subtraction of one restoring step. Because the partial remainder is always
  // below the divisor, the shifted value stays under 512 and bit 9 is a clean sign bit.
  always_comb begin
    trial    = {prem_reg, work_reg[15]} - {2'b00, dsr_reg};
    trial_ok = ~trial[9];
  end

  // Control FSM, datapath iteration and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      work_reg    <= '0;
      dsr_reg     <= '0;
      prem_reg    <= '0;
      cnt_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            work_reg  <= dividend;
            dsr_reg   <= divisor;
            prem_reg  <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= (divisor == 8'd0) ? FIN : CALC;
          end
        end
        CALC: begin
          if (trial_ok) begin
            prem_reg <= trial[8:0];
            work_reg <= {work_reg[14:0], 1'b1};
          end else begin
            prem_reg <= {prem_reg[7:0], work_reg[15]};
            work_reg <= {work_reg[14:0], 1'b0};
          end
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd15) begin
            state_reg <= FIN;
          end
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (dsr_reg == 8'd0) begin
            // work_reg still holds the untouched dividend here
            quotient    <= 16'hFFFF;
            remainder   <= work_reg[7:0];
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= work_reg;
            remainder   <= prem_reg[7:0];
            div_by_zero <= 1'b0;
          end
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div16.sv
// tb_seq_div16: directed and randomized checks of seq_div16 against plain-arithmetic
// expectations (integer divide / modulo, saturated result for a zero divisor).
`timescale 1ns/1ps
module tb_seq_div16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int tests_run;
  int tests_failed;

  localparam int N_RANDOM = 3000;

  seq_div16 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present operands before an edge, hold start for exactly that edge (E0),
  // then scramble the operand inputs to show they are no longer used.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Count edges after the current point until done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 40);
  endtask

  // Expected results from the arithmetic definition of division.
  task automatic expect_result(input logic [15:0] a, input logic [7:0] b,
                               output logic [15:0] eq, output logic [7:0] er,
                               output logic ez, output int elat);
    if (b == 8'd0) begin
      eq = 16'hFFFF;
      er = a[7:0];
      ez = 1'b1;
      elat = 1;
    end else begin
      eq = 16'(int'(a) / int'(b));
      er = 8'(int'(a) % int'(b));
      ez = 1'b0;
      elat = 17;
    end
  endtask

  task automatic run_check(input string tag, input logic [15:0] a, input logic [7:0] b);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          elat;
    int          lat;
    expect_result(a, b, eq, er, ez, elat);
    start_op(a, b);
    check({tag, " busy"}, 32'(busy), 32'(1));
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
    check({tag, " busy_low"}, 32'(busy), 32'(0));
    $display("[TB] %s: %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d", tag, a, b,
             quotient, remainder, div_by_zero, lat);
  endtask

  initial begin
    int lat;
    int done_seen;
    logic [15:0] ra;
    logic [7:0]  rb;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          elat;
    int          rand_fail_before;

    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset state
    #12;
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset quotient", 32'(quotient), 32'(0));
    check("reset remainder", 32'(remainder), 32'(0));
    check("reset div_by_zero", 32'(div_by_zero), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Idle with start low: nothing moves
    repeat (3) @(posedge clk);
    #1;
    check("idle done", 32'(done), 32'(0));
    check("idle busy", 32'(busy), 32'(0));

    // Basic and boundary operands
    run_check("1000/7", 16'd1000, 8'd7);
    run_check("FFFF/1", 16'hFFFF, 8'd1);
    run_check("FFFF/FF", 16'hFFFF, 8'hFF);
    run_check("3/200", 16'd3, 8'd200);
    run_check("0/9", 16'd0, 8'd9);
    run_check("5/0", 16'd5, 8'd0);
    run_check("10/3", 16'd10, 8'd3);

    // Results hold during CALC of the next operation
    start_op(16'd1000, 8'd7);
    repeat (6) @(posedge clk);
    #1;
    check("hold quotient", 32'(quotient), 32'(3));
    check("hold remainder", 32'(remainder), 32'(1));
    check("hold done", 32'(done), 32'(0));
    wait_done(lat);
    check("hold latency", 32'(lat), 32'(11));
    check("hold final quotient", 32'(quotient), 32'(142));

    // Second start at E5 is ignored
    start_op(16'd1000, 8'd7);
    repeat (4) @(posedge clk);
    #1;
    dividend = 16'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("ignore latency", 32'(lat), 32'(12));
    check("ignore quotient", 32'(quotient), 32'(142));
    check("ignore remainder", 32'(remainder), 32'(6));
    $display("[TB] start at E5 ignored: q=%0d r=%0d", quotient, remainder);

    // Start during the done cycle is accepted, done again 17 edges later
    check("b2b done_cycle", 32'(done), 32'(1));
    dividend = 16'd200;
    divisor  = 8'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b busy", 32'(busy), 32'(1));
    wait_done(lat);
    check("b2b latency", 32'(lat), 32'(17));
    check("b2b quotient", 32'(quotient), 32'(22));
    check("b2b remainder", 32'(remainder), 32'(2));
    $display("[TB] back-to-back 200/9: q=%0d r=%0d lat=%0d", quotient, remainder, lat);

    // Asynchronous reset at E8 aborts the operation
    start_op(16'd1000, 8'd7);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'(0));
    check("abort done", 32'(done), 32'(0));
    check("abort quotient", 32'(quotient), 32'(0));
    check("abort remainder", 32'(remainder), 32'(0));
    check("abort div_by_zero", 32'(div_by_zero), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort no_done", 32'(done_seen), 32'(0));
    $display("[TB] reset mid-operation: done pulses afterwards=%0d", done_seen);
    run_check("post-reset 200/9", 16'd200, 8'd9);

    // Randomized operands against the arithmetic model
    rand_fail_before = tests_failed;
    for (int i = 0; i < N_RANDOM; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      expect_result(ra, rb, eq, er, ez, elat);
      start_op(ra, rb);
      wait_done(lat);
      check("rand latency", 32'(lat), 32'(elat));
      check("rand quotient", 32'(quotient), 32'(eq));
      check("rand remainder", 32'(remainder), 32'(er));
      check("rand div_by_zero", 32'(div_by_zero), 32'(ez));
    end
    $display("[TB] random batch: %0d operations, %0d wrong comparisons", N_RANDOM,
             tests_failed - rand_fail_before);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
